// File: rtl/accel_spi_reader.sv
// SPI mode-0 master for an ADXL362-class accelerometer. It switches the sensor to measure
// mode once, then reads the 8-bit X/Y data registers on every sample tick.
module accel_spi_reader #(
  parameter int unsigned CLK_DIV        = 5,
  parameter int unsigned STARTUP_CYCLES = 250000,
  parameter int unsigned SAMPLE_PERIOD  = 500000
) (
  input  logic       clk,
  input  logic       arst_n,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  input  logic       i_miso,
  output logic [7:0] o_accel_x,
  output logic [7:0] o_accel_y,
  output logic       o_valid,
  output logic       o_ready
);

  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned StartW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned SmpW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [31:0] InitFrame = 32'h0A2D_0200;
  localparam logic [31:0] ReadFrame = 32'h0B08_0000;

  typedef enum logic [2:0] {StStartup, StInit, StIdle, StRead, StGap} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [6:0]        half_q, half_d;
  logic [StartW-1:0] start_q, start_d;
  logic [SmpW-1:0]   smp_q, smp_d;
  logic [31:0]       tx_q, tx_d;
  logic [15:0]       rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              last_rd_q, last_rd_d;
  logic [7:0]        ax_q, ax_d, ay_q, ay_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              tick;
  logic [6:0]        last_half;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    start_d   = start_q;
    smp_d     = smp_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    last_rd_d = last_rd_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    valid_d   = 1'b0;
    ready_d   = ready_q;

    // Half-periods 0..2N: setup, N high/low pairs, and the final low half acts as the hold.
    last_half = (state_q == StRead) ? 7'd64 : 7'd48;
    tick      = ready_q && (smp_q == SmpW'(SAMPLE_PERIOD - 1));
    if (ready_q) begin
      smp_d = tick ? '0 : smp_q + 1'b1;
    end

    case (state_q)
      StStartup: begin
        if (start_q == StartW'(STARTUP_CYCLES - 1)) begin
          state_d = StInit;
          cs_n_d  = 1'b0;
          tx_d    = InitFrame;
          div_d   = '0;
          half_d  = '0;
        end else begin
          start_d = start_q + 1'b1;
        end
      end
      StInit, StRead: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (half_q == last_half) begin
            cs_n_d    = 1'b1;
            sclk_d    = 1'b0;
            tx_d      = '0;
            state_d   = StGap;
            last_rd_d = (state_q == StRead);
            if (state_q == StInit) begin
              ready_d = 1'b1;
            end
          end else if (!half_q[0]) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], i_miso};
            half_d = half_q + 7'd1;
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[30:0], 1'b0};
            half_d = half_q + 7'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if ((div_q == '0) && last_rd_q) begin
          ax_d      = rx_q[15:8];
          ay_d      = rx_q[7:0];
          valid_d   = 1'b1;
          last_rd_d = 1'b0;
        end
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StIdle: begin
        if (tick) begin
          state_d = StRead;
          cs_n_d  = 1'b0;
          tx_d    = ReadFrame;
          div_d   = '0;
          half_d  = '0;
        end
      end
      default: state_d = StStartup;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= StStartup;
      div_q     <= '0;
      half_q    <= '0;
      start_q   <= '0;
      smp_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      last_rd_q <= 1'b0;
      ax_q      <= '0;
      ay_q      <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      start_q   <= start_d;
      smp_q     <= smp_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      last_rd_q <= last_rd_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign o_sclk    = sclk_q;
  assign o_mosi    = tx_q[31];
  assign o_cs_n    = cs_n_q;
  assign o_accel_x = ax_q;
  assign o_accel_y = ay_q;
  assign o_valid   = valid_q;
  assign o_ready   = ready_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: an SPI slave model plus a cycle monitor measure every frame;
// a second instance with a short sample period exercises dropped ticks.
module tb_accel_spi_reader;

  logic       clk = 1'b0;
  logic       arst_n, arst2_n;
  logic       sclk, mosi, cs_n, miso;
  logic [7:0] ax, ay;
  logic       valid, ready;
  logic       sclk2, mosi2, cs2_n, miso2;
  logic [7:0] ax2, ay2;
  logic       valid2, ready2;

  always #5 clk = ~clk;

  accel_spi_reader #(.CLK_DIV(5), .STARTUP_CYCLES(100), .SAMPLE_PERIOD(1000)) u_dut (
    .clk(clk), .arst_n(arst_n), .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .i_miso(miso),
    .o_accel_x(ax), .o_accel_y(ay), .o_valid(valid), .o_ready(ready)
  );

  accel_spi_reader #(.CLK_DIV(5), .STARTUP_CYCLES(100), .SAMPLE_PERIOD(330)) u_dut2 (
    .clk(clk), .arst_n(arst2_n), .o_sclk(sclk2), .o_mosi(mosi2), .o_cs_n(cs2_n),
    .i_miso(miso2), .o_accel_x(ax2), .o_accel_y(ay2), .o_valid(valid2), .o_ready(ready2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Slave configuration (set by the main sequence).
  logic [7:0] slave_x = 8'h00, slave_y = 8'h00;
  logic       slave_all_ones = 1'b0;

  // Monitor state for u_dut, all sampled on negedge clk.
  int          cyc = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]  prev_x = 8'h00, prev_y = 8'h00;
  logic [31:0] slave_sr = '0, cur_mosi = '0, f_mosi = '0;
  int cs_fall_cyc = 0, cur_interval = 0, cur_first = 0, cur_rises = 0;
  int last_rise = 0, last_fall = 0, hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
  int frames = 0, f_rises = 0, f_len = 0, f_first = 0, f_hold = 0, f_fall = 0, f_rise = 0;
  int f_interval = 0, f_hi_min = 0, f_hi_max = 0, f_lo_min = 0, f_lo_max = 0;
  int gap_min = 100000, ready_rise_cyc = -1, valid_pulses = 0, valid_cyc = 0;
  bit valid_long = 1'b0, unstable = 1'b0;

  initial begin
    miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_cs && !cs_n) begin
        if (frames > 0 && (cyc - f_rise) < gap_min) gap_min = cyc - f_rise;
        cur_interval = cyc - cs_fall_cyc;
        cs_fall_cyc  = cyc;
        cur_rises    = 0;
        cur_mosi     = '0;
        hi_min = 100000; hi_max = 0; lo_min = 100000; lo_max = 0;
        slave_sr = slave_all_ones ? 32'hFFFF_FFFF : {16'h0000, slave_x, slave_y};
        miso     = slave_sr[31];
      end
      if (!prev_sclk && sclk) begin
        if (cur_rises == 0) cur_first = cyc - cs_fall_cyc;
        else begin
          if (cyc - last_fall < lo_min) lo_min = cyc - last_fall;
          if (cyc - last_fall > lo_max) lo_max = cyc - last_fall;
        end
        cur_rises++;
        cur_mosi  = {cur_mosi[30:0], mosi};
        last_rise = cyc;
      end
      if (prev_sclk && !sclk) begin
        if (cyc - last_rise < hi_min) hi_min = cyc - last_rise;
        if (cyc - last_rise > hi_max) hi_max = cyc - last_rise;
        last_fall = cyc;
        if (!cs_n) begin
          slave_sr = slave_sr << 1;
          miso     = slave_sr[31];
        end
      end
      if (!prev_cs && cs_n) begin
        f_rises = cur_rises; f_mosi = cur_mosi; f_first = cur_first;
        f_len = cyc - cs_fall_cyc; f_hold = cyc - last_fall;
        f_fall = cs_fall_cyc; f_rise = cyc; f_interval = cur_interval;
        f_hi_min = hi_min; f_hi_max = hi_max; f_lo_min = lo_min; f_lo_max = lo_max;
        frames++;
        miso = 1'b0;
      end
      if (!prev_ready && ready) ready_rise_cyc = cyc;
      if (valid) begin
        if (prev_valid) valid_long = 1'b1;
        else begin
          valid_pulses++;
          valid_cyc = cyc;
        end
      end else if (ax !== prev_x || ay !== prev_y) begin
        unstable = 1'b1;
      end
      prev_cs = cs_n; prev_sclk = sclk; prev_valid = valid; prev_ready = ready;
      prev_x = ax; prev_y = ay;
    end
  end

  // Slave and monitor for u_dut2: fixed X=0x3C, Y=0xA5.
  int          c2 = 0, fall2 = 0, interval2 = 0, falls2 = 0, len2 = 0, valids2 = 0;
  logic        pcs2 = 1'b1, psclk2 = 1'b0;
  logic [31:0] sr2 = '0;
  bit          bad_len2 = 1'b0;
  initial begin
    miso2 = 1'b0;
    forever begin
      @(negedge clk);
      c2++;
      if (pcs2 && !cs2_n) begin
        interval2 = c2 - fall2;
        fall2     = c2;
        falls2++;
        sr2   = 32'h0000_3CA5;
        miso2 = sr2[31];
      end
      if (psclk2 && !sclk2 && !cs2_n) begin
        sr2   = sr2 << 1;
        miso2 = sr2[31];
      end
      if (!pcs2 && cs2_n) begin
        len2 = c2 - fall2;
        if (falls2 > 1 && len2 != 325) bad_len2 = 1'b1;
        miso2 = 1'b0;
      end
      if (valid2) valids2++;
      pcs2 = cs2_n; psclk2 = sclk2;
    end
  end

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames < n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    if (frames < n) check("frame_timeout", frames, n);
  endtask

  task automatic wait_valid(input int n);
    int t = 0;
    while (valid_pulses < n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    if (valid_pulses < n) check("valid_timeout", valid_pulses, n);
  endtask

  int rel_cyc, base_frames, base_valids, t;

  initial begin
    arst_n  = 1'b0;
    arst2_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_x", ax, 0);
    check("rst_y", ay, 0);
    check("rst_valid", valid, 0);
    check("rst_ready", ready, 0);
    slave_x = 8'h05;
    slave_y = 8'hFB;
    arst_n  = 1'b1;
    arst2_n = 1'b1;
    rel_cyc = cyc;

    wait_frames(1);
    check("init_start_delay", f_fall - rel_cyc, 100);
    check("init_rises", f_rises, 24);
    check("init_mosi", f_mosi[23:0], 24'h0A2D02);
    check("init_len", f_len, 49 * 5);
    check("ready_at_cs_rise", ready_rise_cyc, f_rise);
    repeat (3) @(negedge clk);
    #1;
    check("init_no_valid", valid_pulses, 0);

    wait_frames(2);
    check("rd_rises", f_rises, 32);
    check("rd_mosi", f_mosi, 32'h0B08_0000);
    check("rd_len", f_len, 325);
    check("rd_first_rise", f_first, 5);
    check("rd_hold", f_hold, 5);
    check("sck_hi_min", f_hi_min, 5);
    check("sck_hi_max", f_hi_max, 5);
    check("sck_lo_min", f_lo_min, 5);
    check("sck_lo_max", f_lo_max, 5);
    wait_valid(1);
    check("valid_latency", valid_cyc - f_rise, 1);
    check("x_pos5", $signed(ax), -64'sd0 + 5);
    check("y_neg5", $signed(ay), -5);
    slave_all_ones = 1'b1;

    wait_valid(2);
    check("x_ones", $signed(ax), -1);
    check("y_ones", $signed(ay), -1);
    check("read_interval_a", f_interval, 1000);
    slave_all_ones = 1'b0;
    slave_x = 8'h7F;
    slave_y = 8'h80;

    wait_valid(3);
    check("x_max", $signed(ax), 127);
    check("y_min", $signed(ay), -128);
    check("read_interval_b", f_interval, 1000);
    check("valid_one_cycle", valid_long, 0);
    check("outputs_stable", unstable, 0);
    check("cs_gap_min_ok", gap_min >= 5, 1);
    check("ready_held", ready, 1);

    // Second instance: ticks that land in READ/GAP are dropped, so reads come every 660.
    check("p330_falls", falls2 >= 3, 1);
    check("p330_interval", interval2, 660);
    check("p330_len_ok", bad_len2, 0);
    check("p330_x", ax2, 8'h3C);
    check("p330_y", ay2, 8'hA5);
    check("p330_valids", valids2 >= 2, 1);

    // Reset in the middle of a READ, at its 20th SCK rise.
    t = 0;
    while (!(!cs_n && cur_rises == 20) && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check("mid_rd_reached", cur_rises, 20);
    base_valids = valid_pulses;
    arst_n = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_x", ax, 0);
    check("mid_rst_y", ay, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_valid", valid, 0);
    base_frames = frames;
    arst_n  = 1'b1;
    rel_cyc = cyc;
    wait_frames(base_frames + 1);
    check("reinit_delay", f_fall - rel_cyc, 100);
    check("reinit_rises", f_rises, 24);
    check("reinit_mosi", f_mosi[23:0], 24'h0A2D02);
    check("mid_rst_no_valid", valid_pulses, base_valids);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
Name: accel_spi_reader

Overview:
SPI master that initialises an ADXL362-class 3-axis accelerometer and periodically reads its 8-bit X/Y acceleration registers. It produces signed 8-bit i_accel_x/i_accel_y values for the ball positioner, so it is the producer end of the acceleration interface. It sits between the board's accelerometer pins and the game physics logic.

Parameters:
CLK_DIV, 5, clk cycles per SCK half-period (SCK = clk/(2*CLK_DIV)); must be >=2.
STARTUP_CYCLES, 250000, clk cycles after reset before the init transaction (sensor power-up).
SAMPLE_PERIOD, 500000, clk cycles between read-transaction starts; must be >= 96*CLK_DIV.

Ports:
clk  input  1  system clock
arst_n  input  1  reset; synchronous, active-low
o_sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
o_mosi  output  1  SPI data to sensor, MSB first
o_cs_n  output  1  SPI chip select, active-low
i_miso  input  1  SPI data from sensor
o_accel_x  output  8  signed X acceleration, two's complement
o_accel_y  output  8  signed Y acceleration, two's complement
o_valid  output  1  one-cycle pulse when o_accel_x/o_accel_y update
o_ready  output  1  high once the init transaction has completed

Behaviour:
- Reset is sampled on posedge clk only. While arst_n=0 at a clk edge: o_cs_n=1, o_sclk=0, o_mosi=0, o_accel_x=0, o_accel_y=0, o_valid=0, o_ready=0, FSM=STARTUP, all counters 0.
- All outputs are registered. No combinational path from i_miso to any output.
- FSM states:
  - STARTUP: count STARTUP_CYCLES, then go to INIT.
  - INIT: 24-bit transaction; MOSI frame 0x0A,0x2D,0x02 (write POWER_CTL = measure mode). MISO is ignored. On completion go to GAP with o_ready set to 1.
  - IDLE: wait for the sample tick.
  - READ: 32-bit transaction; MOSI frame 0x0B,0x08,0x00,0x00 (read from XDATA). MISO bits 15..8 hold X and bits 7..0 hold Y.
  - GAP: CLK_DIV cycles with cs_n high, then go to IDLE.
- o_ready stays 1 once set, until the next reset.
- Transaction timing, with N = 24 or 32 and cycle 0 = the cycle in which cs_n goes low:
  - o_mosi presents bit N-1 at cycle 0.
  - SCK rises at cycles CLK_DIV + k*2*CLK_DIV and falls CLK_DIV cycles after each rise, for k = 0..N-1.
  - i_miso is captured on the clk edge where o_sclk goes 0->1.
  - o_mosi advances to the next bit on the clk edge where o_sclk goes 1->0.
  - After the last falling edge, cs_n is held low a further CLK_DIV cycles (hold), then goes high.
  - Total cs_n-low time: (2N+1)*CLK_DIV cycles.
- Read completion: in the cycle after cs_n rises, o_accel_x and o_accel_y load from the shift register and o_valid=1 for exactly one cycle. The outputs hold their values until the next completed read.
- Sample tick:
  - A free-running counter, enabled from the cycle o_ready goes high, wraps every SAMPLE_PERIOD cycles and generates the tick.
  - A tick that arrives while not in IDLE is dropped, not queued.
  - The first READ starts on the first tick after init.
- o_sclk is 0 whenever cs_n=1. o_mosi is 0 whenever cs_n=1.
- Reset asserted mid-transaction: on the next clk edge cs_n=1 and sclk=0, the partial frame is discarded, o_valid never pulses, and the sequence restarts from STARTUP.
- Counter widths are sized with $clog2 of their parameter. Arithmetic is unsigned except the outputs, which are reinterpreted as signed.

Test Plan:
- Use a bench SPI slave model. Run with CLK_DIV=5, STARTUP_CYCLES=100, SAMPLE_PERIOD=1000.
- Reset release -> cs_n high for 100 cycles; then the INIT frame shows exactly 24 SCK rises with MOSI bytes 0x0A,0x2D,0x02; o_ready rises in the cycle cs_n rises; no o_valid pulse.
- First tick; slave returns X=0x05, Y=0xFB -> MOSI bytes 0x0B,0x08,0x00,0x00; after cs_n rises, o_accel_x=5, o_accel_y=-5, o_valid high for 1 cycle.
- Timing check -> SCK high and low each exactly 5 cycles; cs_n-low to first SCK rise = 5 cycles; last fall to cs_n rise = 5 cycles; cs_n-low time = 325 cycles for READ; cs_n high >= 5 cycles between frames.
- Slave drives MISO=1 constantly -> o_accel_x=-1, o_accel_y=-1; the next read with slave X=0x7F, Y=0x80 -> 127 and -128; consecutive cs_n falling edges are 1000 cycles apart; outputs are stable between pulses.
- Assert arst_n=0 for one cycle at the 20th SCK rise of a READ -> next cycle cs_n=1, sclk=0, outputs 0, o_ready=0; no o_valid; the INIT frame repeats 100 cycles after release.
- Parameter check with SAMPLE_PERIOD=330 (at the 96*CLK_DIV boundary is 480; use a bench-only override) -> ticks landing during READ/GAP are dropped; reads still complete intact and no frame is corrupted.
